// File: rtl/rv32im_pkg.sv
// rv32im_pkg: shared encodings for the RV32IM execute stage.
// Funct3 codes, ALU ops, forward selects and the M-unit FSM states.
package rv32im_pkg;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;
   localparam logic [2:0] ALU_SLL = 3'd5;
   localparam logic [2:0] ALU_SRL = 3'd6;
   localparam logic [2:0] ALU_SRA = 3'd7;

   localparam logic [1:0] FWD_REG   = 2'd0;
   localparam logic [1:0] FWD_MEMWB = 2'd1;
   localparam logic [1:0] FWD_EXMEM = 2'd2;
   localparam logic [1:0] FWD_ZERO  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } md_state_e;

   function automatic logic f3_sgn_a(input logic [2:0] f3);
      return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU)
          || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic f3_sgn_b(input logic [2:0] f3);
      return (f3 == F3_MUL) || (f3 == F3_MULH)
          || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/rv32im_muldiv.sv
// rv32im_muldiv: iterative M unit (shift-add multiply, restoring divide).
// Define RV32IM_FAST_MUL_EN for a single-cycle multiplier.
module rv32im_muldiv #(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            i_valid,
   input  logic            i_mop,
   input  logic            i_flush,
   input  logic [2:0]      i_f3,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic            o_stall,
   output logic            o_valid,
   output logic [XLEN-1:0] o_result
);
   import rv32im_pkg::*;

   localparam int CNT_W = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   md_state_e         r_state, w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_f3;
   logic [XLEN-1:0]   r_hi, r_lo, r_b;
   logic              r_neg, r_negr;
   logic              w_accept, w_sa, w_sb;
   logic              w_div0, w_ovf, w_fmul, w_fast;
   logic [XLEN-1:0]   w_ma, w_mb;
   logic [XLEN:0]     w_sum, w_rs, w_df;
   logic [2*XLEN-1:0] w_p, w_pf;

   assign w_accept = i_valid & i_mop & ~i_flush & ~RESET;
   assign w_sa     = i_a[XLEN-1] & f3_sgn_a(i_f3);
   assign w_sb     = i_b[XLEN-1] & f3_sgn_b(i_f3);
   assign w_ma     = w_sa ? -i_a : i_a;
   assign w_mb     = w_sb ? -i_b : i_b;
   assign w_div0   = i_f3[2] & (i_b == '0);
   assign w_ovf    = i_f3[2] & ~i_f3[0] & (i_a == MIN_NEG) & (&i_b);

`ifdef RV32IM_FAST_MUL_EN
   logic [2*XLEN-1:0] w_pm;
   assign w_pm   = (2*XLEN)'(w_ma) * (2*XLEN)'(w_mb);
   assign w_fmul = ~i_f3[2];
`else
   assign w_fmul = 1'b0;
`endif

   assign w_fast = w_div0 | w_ovf | w_fmul;

   // one radix-2 step on magnitudes; signs are re-applied at the output
   assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
   assign w_rs  = {r_hi, r_lo[XLEN-1]};
   assign w_df  = w_rs - {1'b0, r_b};

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      o_stall = 1'b0;
      o_valid = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               o_stall = 1'b1;
               w_next  = w_fast ? ST_DONE : ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (i_flush) begin
               w_next = ST_IDLE;
            end else begin
               o_stall = 1'b1;
               if (r_cnt == CNT_W'(1)) w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            o_valid = ~i_flush;
            w_next  = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_cnt  <= '0;
         r_f3   <= '0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_b    <= '0;
         r_neg  <= 1'b0;
         r_negr <= 1'b0;
      end else if (r_state == ST_IDLE && w_accept) begin
         r_f3   <= i_f3;
         r_cnt  <= w_fast ? '0 : CNT_W'(XLEN);
         r_neg  <= w_sa ^ w_sb;
         r_negr <= w_sa;
         r_hi   <= '0;
         r_lo   <= i_f3[2] ? w_ma : w_mb;
         r_b    <= i_f3[2] ? w_mb : w_ma;
         if (w_div0) begin
            r_neg  <= 1'b0;
            r_negr <= 1'b0;
            r_hi   <= i_a;
            r_lo   <= '1;
         end else if (w_ovf) begin
            r_neg  <= 1'b0;
            r_negr <= 1'b0;
            r_lo   <= i_a;
         end
`ifdef RV32IM_FAST_MUL_EN
         else if (w_fmul) begin
            {r_hi, r_lo} <= w_pm;
         end
`endif
      end else if (r_state == ST_BUSY) begin
         r_cnt <= r_cnt - CNT_W'(1);
         if (r_f3[2]) begin
            r_hi <= w_df[XLEN] ? w_rs[XLEN-1:0] : w_df[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], ~w_df[XLEN]};
         end else begin
            {r_hi, r_lo} <= {w_sum, r_lo[XLEN-1:1]};
         end
      end
   end

   assign w_p  = {r_hi, r_lo};
   assign w_pf = r_neg ? -w_p : w_p;

   always_comb begin
      o_result = '0;
      unique case (r_f3)
         F3_MUL:                       o_result = w_pf[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: o_result = w_pf[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:              o_result = r_neg ? -r_lo : r_lo;
         default:                      o_result = r_negr ? -r_hi : r_hi;
      endcase
   end

endmodule

// File: rtl/rv32im_ex.sv
// rv32im_ex: RV32IM execute stage with forwarding, base ALU and M unit.
// RV32IM_FAST_MUL_EN selects the single-cycle multiplier in rv32im_muldiv.
module rv32im_ex #(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            VALID_IN,
   input  logic            FLUSH,
   input  logic [1:0]      CTRL_WB_IN,
   input  logic [2:0]      CTRL_MEM_IN,
   input  logic [4:0]      CTRL_EX_IN,
   input  logic [XLEN-1:0] PC_IN,
   input  logic [XLEN-1:0] REG1_IN,
   input  logic [XLEN-1:0] REG2_IN,
   input  logic [XLEN-1:0] IMM_IN,
   input  logic [31:0]     INST_IN,
   input  logic [XLEN-1:0] EX_MEM_VAL,
   input  logic [XLEN-1:0] MEM_WB_VAL,
   input  logic [1:0]      CTRL_MUX1,
   input  logic [1:0]      CTRL_MUX2,
   output logic [1:0]      CTRL_WB_OUT,
   output logic [2:0]      CTRL_MEM_OUT,
   output logic [XLEN-1:0] PCIMM_OUT,
   output logic [XLEN-1:0] ALURESULT,
   output logic [2:0]      COMPARE,
   output logic [XLEN-1:0] REG2_OUT,
   output logic [31:0]     INST_OUT,
   output logic            VALID_OUT,
   output logic            STALL_OUT
);
   import rv32im_pkg::*;

   localparam int SH_W = $clog2(XLEN);

   logic [XLEN-1:0] w_a, w_fwd2, w_b, w_alu, w_md_res;
   logic [SH_W-1:0] w_sh;
   logic [2:0]      w_cmp;
   logic            w_mop, w_md_stall, w_md_valid;

   assign w_mop = CTRL_EX_IN[4];

   always_comb begin
      w_a = '0;
      unique case (CTRL_MUX1)
         FWD_REG:   w_a = REG1_IN;
         FWD_MEMWB: w_a = MEM_WB_VAL;
         FWD_EXMEM: w_a = EX_MEM_VAL;
         FWD_ZERO:  w_a = '0;
         default:   w_a = '0;
      endcase
   end

   always_comb begin
      w_fwd2 = '0;
      unique case (CTRL_MUX2)
         FWD_REG:   w_fwd2 = REG2_IN;
         FWD_MEMWB: w_fwd2 = MEM_WB_VAL;
         FWD_EXMEM: w_fwd2 = EX_MEM_VAL;
         FWD_ZERO:  w_fwd2 = '0;
         default:   w_fwd2 = '0;
      endcase
   end

   assign w_b  = CTRL_EX_IN[0] ? IMM_IN : w_fwd2;
   assign w_sh = w_b[SH_W-1:0];

   always_comb begin
      w_alu = '0;
      unique case (CTRL_EX_IN[3:1])
         ALU_ADD: w_alu = w_a + w_b;
         ALU_SUB: w_alu = w_a - w_b;
         ALU_AND: w_alu = w_a & w_b;
         ALU_OR:  w_alu = w_a | w_b;
         ALU_XOR: w_alu = w_a ^ w_b;
         ALU_SLL: w_alu = w_a << w_sh;
         ALU_SRL: w_alu = w_a >> w_sh;
         ALU_SRA: w_alu = $signed(w_a) >>> w_sh;
         default: w_alu = '0;
      endcase
   end

   // {eq, signed lt, unsigned lt}
   assign w_cmp = {w_a == w_b, $signed(w_a) < $signed(w_b), w_a < w_b};

   rv32im_muldiv #(.XLEN(XLEN)) u_md (
      .CLK      (CLK),
      .RESET    (RESET),
      .i_valid  (VALID_IN),
      .i_mop    (w_mop),
      .i_flush  (FLUSH),
      .i_f3     (INST_IN[14:12]),
      .i_a      (w_a),
      .i_b      (w_b),
      .o_stall  (w_md_stall),
      .o_valid  (w_md_valid),
      .o_result (w_md_res)
   );

   assign CTRL_WB_OUT  = CTRL_WB_IN;
   assign CTRL_MEM_OUT = CTRL_MEM_IN;
   assign INST_OUT     = INST_IN;
   assign REG2_OUT     = w_fwd2;
   assign PCIMM_OUT    = PC_IN + IMM_IN;
   assign ALURESULT    = w_mop ? w_md_res : w_alu;
   assign COMPARE      = w_mop ? 3'b000 : w_cmp;
   assign STALL_OUT    = w_md_stall;
   assign VALID_OUT    = ~RESET & (w_md_valid | (VALID_IN & ~w_mop));

endmodule

// File: tb/tb_rv32im_ex.sv
// tb_rv32im_ex: randomized self-checking bench for rv32im_ex (XLEN=32).
// Expected values come from plain 64-bit arithmetic on the RISC-V M rules.
module tb_rv32im_ex;
   localparam int XLEN = 32;
   localparam logic [31:0] MINV = 32'h8000_0000;

   logic        CLK = 1'b0;
   logic        RESET, VALID_IN, FLUSH;
   logic [1:0]  CTRL_WB_IN, CTRL_MUX1, CTRL_MUX2;
   logic [2:0]  CTRL_MEM_IN;
   logic [4:0]  CTRL_EX_IN;
   logic [31:0] PC_IN, REG1_IN, REG2_IN, IMM_IN, INST_IN;
   logic [31:0] EX_MEM_VAL, MEM_WB_VAL;
   logic [1:0]  CTRL_WB_OUT;
   logic [2:0]  CTRL_MEM_OUT, COMPARE;
   logic [31:0] PCIMM_OUT, ALURESULT, REG2_OUT, INST_OUT;
   logic        VALID_OUT, STALL_OUT;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   rv32im_ex #(.XLEN(XLEN)) dut (
      .CLK(CLK), .RESET(RESET), .VALID_IN(VALID_IN), .FLUSH(FLUSH),
      .CTRL_WB_IN(CTRL_WB_IN), .CTRL_MEM_IN(CTRL_MEM_IN),
      .CTRL_EX_IN(CTRL_EX_IN), .PC_IN(PC_IN), .REG1_IN(REG1_IN),
      .REG2_IN(REG2_IN), .IMM_IN(IMM_IN), .INST_IN(INST_IN),
      .EX_MEM_VAL(EX_MEM_VAL), .MEM_WB_VAL(MEM_WB_VAL),
      .CTRL_MUX1(CTRL_MUX1), .CTRL_MUX2(CTRL_MUX2),
      .CTRL_WB_OUT(CTRL_WB_OUT), .CTRL_MEM_OUT(CTRL_MEM_OUT),
      .PCIMM_OUT(PCIMM_OUT), .ALURESULT(ALURESULT), .COMPARE(COMPARE),
      .REG2_OUT(REG2_OUT), .INST_OUT(INST_OUT),
      .VALID_OUT(VALID_OUT), .STALL_OUT(STALL_OUT)
   );

   function automatic logic [31:0] mk_inst(input logic [2:0] f3);
      return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
   endfunction

   function automatic logic [31:0] fwd(input logic [1:0] s,
         input logic [31:0] r, input logic [31:0] mw, input logic [31:0] em);
      case (s)
         2'd0: return r;
         2'd1: return mw;
         2'd2: return em;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] alu_ref(input logic [2:0] op,
         input logic [31:0] a, input logic [31:0] b);
      int sa;
      sa = a;
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return a << b[4:0];
         3'd6: return a >> b[4:0];
         default: return 32'(sa >>> b[4:0]);
      endcase
   endfunction

   function automatic logic [31:0] m_ref(input logic [2:0] f3,
         input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      int sa, sb;
      sa = a;
      sb = b;
      case (f3)
         3'd0: p = 64'(a) * 64'(b);
         3'd1: p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
         3'd2: p = 64'($signed({{32{a[31]}}, a}) * $signed({32'd0, b}));
         3'd3: p = {32'd0, a} * {32'd0, b};
         default: p = 64'd0;
      endcase
      case (f3)
         3'd0: return p[31:0];
         3'd1, 3'd2, 3'd3: return p[63:32];
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == MINV && b == 32'hFFFF_FFFF) return a;
            return 32'(sa / sb);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == MINV && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_stalls(input logic [2:0] f3,
         input logic [31:0] a, input logic [31:0] b);
      if (f3[2]) begin
         if (b == 0) return 1;
         if (!f3[0] && a == MINV && b == 32'hFFFF_FFFF) return 1;
         return 33;
      end
`ifdef RV32IM_FAST_MUL_EN
      return 1;
`else
      return 33;
`endif
   endfunction

   task automatic go_idle();
      @(posedge CLK); #1;
      VALID_IN   = 1'b0;
      CTRL_EX_IN = 5'd0;
      FLUSH      = 1'b0;
      CTRL_MUX1  = 2'd0;
      CTRL_MUX2  = 2'd0;
   endtask

   // Issue one M op at the next edge, count stall cycles, sample DONE.
   task automatic run_m(input logic [2:0] f3, input logic [31:0] a,
         input logic [31:0] b, input logic use_fwd,
         output logic [31:0] res, output int stalls,
         output logic vout, output logic [2:0] cmp, output int vbusy);
      @(posedge CLK); #1;
      VALID_IN   = 1'b1;
      FLUSH      = 1'b0;
      CTRL_EX_IN = 5'b10000;
      INST_IN    = mk_inst(f3);
      PC_IN      = $urandom;
      IMM_IN     = $urandom;
      REG1_IN    = use_fwd ? $urandom : a;
      EX_MEM_VAL = a;
      MEM_WB_VAL = $urandom;
      CTRL_MUX1  = use_fwd ? 2'd2 : 2'd0;
      REG2_IN    = b;
      CTRL_MUX2  = 2'd0;
      stalls = 0;
      vbusy  = 0;
      vout   = 1'b0;
      res    = 32'd0;
      cmp    = 3'd7;
      for (int i = 0; i < 80; i++) begin
         #3;
         if (STALL_OUT) begin
            stalls++;
            if (VALID_OUT) vbusy++;
         end else begin
            res  = ALURESULT;
            vout = VALID_OUT;
            cmp  = COMPARE;
            break;
         end
         @(posedge CLK); #1;
         if (use_fwd) begin
            EX_MEM_VAL = $urandom;
            MEM_WB_VAL = $urandom;
         end
      end
   endtask

   task automatic test_reset();
      logic [1:0] wb;
      logic [31:0] ins;
      RESET = 1'b1;
      FLUSH = 1'b0;
      VALID_IN = 1'b1;
      CTRL_EX_IN = 5'b10000;
      wb = 2'($urandom);
      ins = $urandom;
      CTRL_WB_IN = wb;
      CTRL_MEM_IN = 3'd5;
      INST_IN = ins;
      PC_IN = 32'h100; IMM_IN = 32'h20;
      REG1_IN = 32'd1; REG2_IN = 32'd2;
      EX_MEM_VAL = 0; MEM_WB_VAL = 0;
      CTRL_MUX1 = 0; CTRL_MUX2 = 0;
      #2;
      total++;
      if (STALL_OUT !== 1'b0) begin
         bad++; $display("FAIL reset_stall got=%b want=0", STALL_OUT);
      end
      total++;
      if (VALID_OUT !== 1'b0) begin
         bad++; $display("FAIL reset_valid got=%b want=0", VALID_OUT);
      end
      total++;
      if (CTRL_WB_OUT !== wb || INST_OUT !== ins || PCIMM_OUT !== 32'h120) begin
         bad++;
         $display("FAIL reset_passthru wb=%h/%h inst=%h/%h pcimm=%h/120",
                  CTRL_WB_OUT, wb, INST_OUT, ins, PCIMM_OUT);
      end
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      VALID_IN = 1'b0;
      CTRL_EX_IN = 5'd0;
      RESET = 1'b0;
      #3;
      total++;
      if (VALID_OUT !== 1'b0 || STALL_OUT !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_idle valid=%b stall=%b want 0/0",
                  VALID_OUT, STALL_OUT);
      end
   endtask

   task automatic test_add_imm();
      @(posedge CLK); #1;
      VALID_IN = 1'b1;
      CTRL_EX_IN = 5'b00001;
      REG1_IN = 32'd5; IMM_IN = 32'd7; REG2_IN = 32'd99;
      CTRL_MUX1 = 0; CTRL_MUX2 = 0;
      #3;
      total++;
      if (ALURESULT !== 32'd12 || STALL_OUT !== 1'b0 || VALID_OUT !== 1'b1) begin
         bad++;
         $display("FAIL add_imm res=%0d stall=%b valid=%b want 12/0/1",
                  ALURESULT, STALL_OUT, VALID_OUT);
      end
      go_idle();
   endtask

   task automatic test_base_random();
      logic [31:0] a, r2, b, er;
      logic [2:0] op, ec;
      logic src;
      for (int i = 0; i < 16; i++) begin
         @(posedge CLK); #1;
         op = 3'($urandom);
         src = 1'($urandom);
         VALID_IN = 1'b1;
         CTRL_EX_IN = {1'b0, op, src};
         CTRL_MUX1 = 2'($urandom);
         CTRL_MUX2 = 2'($urandom);
         REG1_IN = $urandom; REG2_IN = $urandom;
         IMM_IN = (i % 4 == 0) ? REG1_IN : $urandom;
         EX_MEM_VAL = $urandom; MEM_WB_VAL = $urandom;
         PC_IN = $urandom;
         a  = fwd(CTRL_MUX1, REG1_IN, MEM_WB_VAL, EX_MEM_VAL);
         r2 = fwd(CTRL_MUX2, REG2_IN, MEM_WB_VAL, EX_MEM_VAL);
         b  = src ? IMM_IN : r2;
         er = alu_ref(op, a, b);
         ec = {a == b, $signed(a) < $signed(b), a < b};
         #3;
         total++;
         if (ALURESULT !== er || COMPARE !== ec) begin
            bad++;
            $display("FAIL base_alu op=%0d res=%h/%h cmp=%b/%b",
                     op, ALURESULT, er, COMPARE, ec);
         end
         total++;
         if (REG2_OUT !== r2 || PCIMM_OUT !== PC_IN + IMM_IN ||
             VALID_OUT !== 1'b1 || STALL_OUT !== 1'b0) begin
            bad++;
            $display("FAIL base_side reg2=%h/%h valid=%b stall=%b",
                     REG2_OUT, r2, VALID_OUT, STALL_OUT);
         end
      end
      go_idle();
   endtask

   task automatic test_div_fwd();
      logic [31:0] res;
      int st, vb;
      logic v;
      logic [2:0] c;
      run_m(3'd4, 32'd100, 32'd7, 1'b1, res, st, v, c, vb);
      total++;
      if (res !== 32'd14 || st != 33 || v !== 1'b1 || vb != 0) begin
         bad++;
         $display("FAIL div_fwd res=%0d/14 stalls=%0d/33 valid=%b vbusy=%0d",
                  res, st, v, vb);
      end
      total++;
      if (c !== 3'd0) begin
         bad++; $display("FAIL m_compare got=%b want=000", c);
      end
      go_idle();
      run_m(3'd6, 32'd100, 32'd7, 1'b1, res, st, v, c, vb);
      total++;
      if (res !== 32'd2 || st != 33 || v !== 1'b1) begin
         bad++;
         $display("FAIL rem_fwd res=%0d/2 stalls=%0d/33 valid=%b", res, st, v);
      end
      go_idle();
   endtask

   task automatic test_mul();
      logic [31:0] res;
      int st, vb, es;
      logic v;
      logic [2:0] c;
      es = exp_stalls(3'd0, 32'd7, 32'hFFFF_FFFD);
      run_m(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, res, st, v, c, vb);
      total++;
      if (res !== 32'hFFFF_FFEB || st != es || v !== 1'b1) begin
         bad++;
         $display("FAIL mul res=%h/FFFFFFEB stalls=%0d/%0d valid=%b",
                  res, st, es, v);
      end
      go_idle();
      run_m(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res, st, v, c, vb);
      total++;
      if (res !== 32'hFFFF_FFFE || st != es || v !== 1'b1) begin
         bad++;
         $display("FAIL mulhu res=%h/FFFFFFFE stalls=%0d/%0d valid=%b",
                  res, st, es, v);
      end
      go_idle();
   endtask

   task automatic test_div_special();
      logic [2:0] f3s [4];
      logic [31:0] as [4], bs [4], ex [4];
      logic [31:0] res;
      int st, vb;
      logic v;
      logic [2:0] c;
      f3s = '{3'd4, 3'd6, 3'd4, 3'd6};
      as  = '{32'd5, 32'd5, MINV, MINV};
      bs  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      ex  = '{32'hFFFF_FFFF, 32'd5, MINV, 32'd0};
      for (int i = 0; i < 4; i++) begin
         run_m(f3s[i], as[i], bs[i], 1'b0, res, st, v, c, vb);
         total++;
         if (res !== ex[i] || st != 1 || v !== 1'b1) begin
            bad++;
            $display("FAIL div_special%0d res=%h/%h stalls=%0d/1 valid=%b",
                     i, res, ex[i], st, v);
         end
         go_idle();
      end
   endtask

   task automatic test_random_m();
      logic [2:0] f3;
      logic [31:0] a, b, er, res;
      int st, vb, es;
      logic v;
      logic [2:0] c;
      for (int i = 0; i < 14; i++) begin
         f3 = 3'($urandom);
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = 32'd0;
            1: b = $urandom_range(1, 15);
            2: begin b = 32'hFFFF_FFFF; if (i % 2 == 0) a = MINV; end
            default: b = $urandom;
         endcase
         er = m_ref(f3, a, b);
         es = exp_stalls(f3, a, b);
         run_m(f3, a, b, 1'(i % 2), res, st, v, c, vb);
         total++;
         if (res !== er || st != es || v !== 1'b1 || vb != 0) begin
            bad++;
            $display("FAIL rand_m f3=%0d a=%h b=%h res=%h/%h stalls=%0d/%0d v=%b",
                     f3, a, b, res, er, st, es, v);
         end
         go_idle();
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r1, r2;
      int s1, s2, vb;
      logic v1, v2;
      logic [2:0] c;
      run_m(3'd5, 32'd1000, 32'd9, 1'b0, r1, s1, v1, c, vb);
      run_m(3'd7, 32'd1000, 32'd9, 1'b0, r2, s2, v2, c, vb);
      total++;
      if (r1 !== 32'd111 || s1 != 33 || v1 !== 1'b1) begin
         bad++;
         $display("FAIL b2b_first res=%0d/111 stalls=%0d/33 v=%b", r1, s1, v1);
      end
      total++;
      if (r2 !== 32'd1 || s2 != 33 || v2 !== 1'b1) begin
         bad++;
         $display("FAIL b2b_second res=%0d/1 stalls=%0d/33 v=%b", r2, s2, v2);
      end
      go_idle();
   endtask

   task automatic start_div_long();
      @(posedge CLK); #1;
      VALID_IN = 1'b1;
      FLUSH = 1'b0;
      CTRL_EX_IN = 5'b10000;
      INST_IN = mk_inst(3'd4);
      REG1_IN = 32'd1000; REG2_IN = 32'd3;
      CTRL_MUX1 = 0; CTRL_MUX2 = 0;
   endtask

   task automatic test_flush();
      int nv, ns;
      start_div_long();
      for (int i = 1; i <= 10; i++) begin
         @(posedge CLK); #1;
      end
      FLUSH = 1'b1;
      VALID_IN = 1'b0;
      CTRL_EX_IN = 5'd0;
      @(posedge CLK); #1;
      FLUSH = 1'b0;
      #3;
      total++;
      if (STALL_OUT !== 1'b0 || VALID_OUT !== 1'b0) begin
         bad++;
         $display("FAIL flush_next stall=%b valid=%b want 0/0",
                  STALL_OUT, VALID_OUT);
      end
      nv = 0; ns = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge CLK); #4;
         if (VALID_OUT) nv++;
         if (STALL_OUT) ns++;
      end
      total++;
      if (nv != 0 || ns != 0) begin
         bad++;
         $display("FAIL flush_quiet valid_cycles=%0d stall_cycles=%0d want 0/0",
                  nv, ns);
      end
      test_add_imm();
   endtask

   task automatic test_reset_midop();
      logic [31:0] res;
      int st, vb, nv;
      logic v;
      logic [2:0] c;
      start_div_long();
      for (int i = 1; i <= 5; i++) begin
         @(posedge CLK); #1;
      end
      RESET = 1'b1;
      VALID_IN = 1'b0;
      CTRL_EX_IN = 5'd0;
      #1;
      total++;
      if (STALL_OUT !== 1'b0 || VALID_OUT !== 1'b0) begin
         bad++;
         $display("FAIL reset_midop stall=%b valid=%b want 0/0",
                  STALL_OUT, VALID_OUT);
      end
      @(posedge CLK); #1;
      RESET = 1'b0;
      nv = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge CLK); #4;
         if (VALID_OUT || STALL_OUT) nv++;
      end
      total++;
      if (nv != 0) begin
         bad++; $display("FAIL reset_abort active_cycles=%0d want 0", nv);
      end
      run_m(3'd5, 32'd9, 32'd3, 1'b0, res, st, v, c, vb);
      total++;
      if (res !== 32'd3 || st != 33 || v !== 1'b1) begin
         bad++;
         $display("FAIL divu_after_reset res=%0d/3 stalls=%0d/33 v=%b",
                  res, st, v);
      end
      go_idle();
   endtask

   initial begin
      test_reset();
      test_add_imm();
      test_base_random();
      test_div_fwd();
      test_mul();
      test_div_special();
      test_random_m();
      test_back_to_back();
      test_flush();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
